// File: rtl/pad_row_feeder.sv
// Row feeder for a 2-stage tap buffer: wraps every row of an upstream sample
// stream with Pad zero beats on each side and reports row/frame boundaries.
module pad_row_feeder #(
  parameter int Width = 24,
  parameter int CntW  = 10,
  parameter int Pad   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CntW-1:0]  cfg_cols,
  input  logic [CntW-1:0]  cfg_rows,
  input  logic             s_valid,
  input  logic [Width-1:0] s_data,
  output logic             s_ready,
  input  logic             stall,
  output logic [Width-1:0] din,
  output logic             en,
  output logic             zero,
  output logic             row_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LPAD, DATA, RPAD} state_t;

  localparam logic [1:0] PadLast = (Pad == 0) ? 2'd0 : 2'(Pad - 1);

  state_t          state;
  logic [CntW-1:0] cols_q;
  logic [CntW-1:0] rows_q;
  logic [CntW-1:0] col_cnt;
  logic [CntW-1:0] row_cnt;
  logic [1:0]      pad_cnt;

  logic pad_state;
  logic issue;
  logic pad_last;
  logic col_last;
  logic row_end;
  logic frame_end;
  logic start_ok;
  logic cfg_ok;

  assign s_ready = (state == DATA) && !stall;

  always_comb begin
    pad_state = (state == LPAD) || (state == RPAD);
    issue     = !stall && (pad_state || ((state == DATA) && s_valid));
    pad_last  = (pad_cnt == PadLast);
    col_last  = (col_cnt == cols_q - CntW'(1));
    row_end   = issue && (((state == RPAD) && pad_last) ||
                          ((state == DATA) && col_last && (Pad == 0)));
    frame_end = row_end && (row_cnt == rows_q - CntW'(1));
    start_ok  = (state == IDLE) && start && !stall;
    cfg_ok    = (cfg_cols != '0) && (cfg_rows != '0);
  end

  // Beat register stage: everything decided this cycle is presented next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cols_q   <= '0;
      rows_q   <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      pad_cnt  <= '0;
      din      <= '0;
      en       <= 1'b0;
      zero     <= 1'b0;
      row_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      en       <= issue;
      zero     <= issue && pad_state;
      row_last <= row_end;
      done     <= frame_end || (start_ok && !cfg_ok);
      // Leaving a frame still counts as busy for the done cycle.
      busy     <= (state != IDLE) || (start_ok && cfg_ok);
      if (issue) din <= pad_state ? '0 : s_data;

      case (state)
        IDLE: begin
          if (start_ok && cfg_ok) begin
            cols_q  <= cfg_cols;
            rows_q  <= cfg_rows;
            col_cnt <= '0;
            row_cnt <= '0;
            pad_cnt <= '0;
            state   <= (Pad == 0) ? DATA : LPAD;
          end
        end
        LPAD: begin
          if (issue) begin
            if (pad_last) begin
              pad_cnt <= '0;
              state   <= DATA;
            end else begin
              pad_cnt <= pad_cnt + 2'd1;
            end
          end
        end
        DATA: begin
          if (issue) begin
            if (col_last) begin
              col_cnt <= '0;
              if (Pad != 0) begin
                state <= RPAD;
              end else if (frame_end) begin
                row_cnt <= '0;
                state   <= IDLE;
              end else begin
                row_cnt <= row_cnt + CntW'(1);
                state   <= DATA;
              end
            end else begin
              col_cnt <= col_cnt + CntW'(1);
            end
          end
        end
        RPAD: begin
          if (issue) begin
            if (pad_last) begin
              pad_cnt <= '0;
              if (frame_end) begin
                row_cnt <= '0;
                state   <= IDLE;
              end else begin
                row_cnt <= row_cnt + CntW'(1);
                state   <= LPAD;
              end
            end else begin
              pad_cnt <= pad_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_row_feeder.sv
// Directed bench for pad_row_feeder with Pad=1: beat sequences, gaps, stalls,
// zero-size frames and reset behaviour.
module tb_pad_row_feeder;
  localparam int Width = 24;
  localparam int CntW  = 10;
  localparam int Pad   = 1;

  logic             clk = 1'b0;
  logic             rst, start, s_valid, s_ready, stall;
  logic             en, zero, row_last, busy, done;
  logic [CntW-1:0]  cfg_cols, cfg_rows;
  logic [Width-1:0] s_data, din;

  pad_row_feeder #(.Width(Width), .CntW(CntW), .Pad(Pad)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .stall(stall),
    .din(din), .en(en), .zero(zero), .row_last(row_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [Width-1:0] src[$];
  logic [Width-1:0] lg_din[$];
  logic             lg_zero[$], lg_last[$], lg_done[$];
  int               lg_pos[$];
  int               done_total, ready_in_stall, en_after_stall, bubbles;
  logic             busy_first, busy_at_done, busy_after;
  bit               timed_out;

  // Launches a frame and logs every beat; cfg inputs are scrambled after launch.
  task automatic run_frame(input int cols, input int rows, input int gap_after,
                           input int gap_len, input int stall_at, input int stall_len);
    int  idx = 0;
    int  gap_rem = gap_len;
    bit  seen_done = 0;
    lg_din.delete(); lg_zero.delete(); lg_last.delete(); lg_done.delete(); lg_pos.delete();
    done_total = 0; ready_in_stall = 0; en_after_stall = 0; bubbles = 0;
    busy_first = 0; busy_at_done = 0; busy_after = 1; timed_out = 1;
    @(negedge clk);
    cfg_cols = CntW'(cols); cfg_rows = CntW'(rows);
    start = 1; stall = 0; s_valid = 1; s_data = src[0];
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (c == 1) busy_first = busy;
      if (seen_done) begin
        busy_after = busy;
        timed_out = 0;
        break;
      end
      if (en) begin
        lg_din.push_back(din); lg_zero.push_back(zero);
        lg_last.push_back(row_last); lg_done.push_back(done); lg_pos.push_back(c);
      end
      if (done) begin
        done_total++;
        busy_at_done = busy;
        seen_done = 1;
      end
      if ((c - 1) >= stall_at && (c - 1) < stall_at + stall_len && en) en_after_stall++;
      start = 0; cfg_cols = '0; cfg_rows = '0;
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      s_valid = 1;
      if (idx == gap_after && gap_rem > 0) begin
        s_valid = 0;
        gap_rem--;
      end
      s_data = (idx < src.size()) ? src[idx] : 24'hBAD0BA;
      #1;
      if (stall && s_ready) ready_in_stall++;
      if (s_valid && s_ready) idx++;
    end
    if (lg_pos.size() > 0) bubbles = lg_pos[$] - lg_pos[0] + 1 - lg_pos.size();
    start = 0; s_valid = 0; stall = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 1; stall = 1; s_valid = 1; s_data = 24'h123456;
    cfg_cols = 10'd3; cfg_rows = 10'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", en); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
    n_checks++; if (din !== '0) begin n_fail++; $display("FAIL reset_din got %h want 0", din); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (row_last !== 1'b0) begin n_fail++; $display("FAIL reset_row_last got %b want 0", row_last); end
    stall = 0; #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    rst = 0; start = 0; s_valid = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_row(input string tag);
    logic [Width-1:0] exp_din[5]  = '{24'h0, 24'h11, 24'h22, 24'h33, 24'h0};
    logic             exp_zero[5] = '{1, 0, 0, 0, 1};
    logic             exp_last[5] = '{0, 0, 0, 0, 1};
    src = '{24'h11, 24'h22, 24'h33};
    run_frame(3, 1, -1, 0, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout got no done want done", tag); end
    n_checks++;
    if (lg_din.size() != 5) begin
      n_fail++; $display("FAIL %s_beats got %0d want 5", tag, lg_din.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (lg_din[i] !== exp_din[i] || lg_zero[i] !== exp_zero[i] || lg_last[i] !== exp_last[i]
            || lg_done[i] !== exp_last[i]) begin
          n_fail++;
          $display("FAIL %s_beat%0d got din=%h zero=%b last=%b done=%b want din=%h zero=%b last=%b done=%b",
                   tag, i, lg_din[i], lg_zero[i], lg_last[i], lg_done[i],
                   exp_din[i], exp_zero[i], exp_last[i], exp_last[i]);
        end
      end
    end
    n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL %s_bubbles got %0d want 0", tag, bubbles); end
    n_checks++; if (done_total != 1) begin n_fail++; $display("FAIL %s_done_count got %0d want 1", tag, done_total); end
    n_checks++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise got %b want 1", tag, busy_first); end
    n_checks++; if (busy_at_done !== 1'b1) begin n_fail++; $display("FAIL %s_busy_done got %b want 1", tag, busy_at_done); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL %s_busy_fall got %b want 0", tag, busy_after); end
  endtask

  task automatic test_two_rows();
    logic [Width-1:0] exp_din[8]  = '{24'h0, 24'hA1, 24'hA2, 24'h0, 24'h0, 24'hB1, 24'hB2, 24'h0};
    logic             exp_zero[8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    logic             exp_last[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic             exp_done[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    src = '{24'hA1, 24'hA2, 24'hB1, 24'hB2};
    run_frame(2, 2, -1, 0, -1, 0);
    n_checks++;
    if (lg_din.size() != 8) begin
      n_fail++; $display("FAIL rows2_beats got %0d want 8", lg_din.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (lg_din[i] !== exp_din[i] || lg_zero[i] !== exp_zero[i] || lg_last[i] !== exp_last[i]
            || lg_done[i] !== exp_done[i]) begin
          n_fail++;
          $display("FAIL rows2_beat%0d got din=%h zero=%b last=%b done=%b want din=%h zero=%b last=%b done=%b",
                   i, lg_din[i], lg_zero[i], lg_last[i], lg_done[i],
                   exp_din[i], exp_zero[i], exp_last[i], exp_done[i]);
        end
      end
    end
    n_checks++; if (done_total != 1) begin n_fail++; $display("FAIL rows2_done_count got %0d want 1", done_total); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL rows2_busy_fall got %b want 0", busy_after); end
  endtask

  task automatic test_gap();
    logic [Width-1:0] exp_din[6] = '{24'h0, 24'h1, 24'h2, 24'h3, 24'h4, 24'h0};
    src = '{24'h1, 24'h2, 24'h3, 24'h4};
    run_frame(4, 1, 2, 3, -1, 0);
    n_checks++;
    if (lg_din.size() != 6) begin
      n_fail++; $display("FAIL gap_beats got %0d want 6", lg_din.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (lg_din[i] !== exp_din[i]) begin
          n_fail++; $display("FAIL gap_din%0d got %h want %h", i, lg_din[i], exp_din[i]);
        end
      end
    end
    n_checks++; if (bubbles != 3) begin n_fail++; $display("FAIL gap_bubbles got %0d want 3", bubbles); end
  endtask

  task automatic test_stall();
    logic [Width-1:0] exp_din[5] = '{24'h0, 24'h51, 24'h52, 24'h53, 24'h0};
    src = '{24'h51, 24'h52, 24'h53};
    run_frame(3, 1, -1, 0, 3, 2);
    n_checks++;
    if (lg_din.size() != 5) begin
      n_fail++; $display("FAIL stall_beats got %0d want 5", lg_din.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (lg_din[i] !== exp_din[i]) begin
          n_fail++; $display("FAIL stall_din%0d got %h want %h", i, lg_din[i], exp_din[i]);
        end
      end
    end
    n_checks++; if (ready_in_stall != 0) begin n_fail++; $display("FAIL stall_ready got %0d want 0", ready_in_stall); end
    n_checks++; if (en_after_stall != 0) begin n_fail++; $display("FAIL stall_en got %0d want 0", en_after_stall); end
    n_checks++; if (bubbles != 2) begin n_fail++; $display("FAIL stall_bubbles got %0d want 2", bubbles); end
  endtask

  task automatic test_zero_cfg();
    int en_seen = 0;
    int busy_seen = 0;
    @(negedge clk);
    cfg_cols = 10'd0; cfg_rows = 10'd2; start = 1; s_valid = 1;
    @(negedge clk);
    start = 0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zcfg_done got %b want 1", done); end
    for (int i = 0; i < 4; i++) begin
      if (en) en_seen++;
      if (busy) busy_seen++;
      @(negedge clk);
      if (i == 0) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zcfg_done_pulse got %b want 0", done); end
      end
    end
    n_checks++; if (en_seen != 0) begin n_fail++; $display("FAIL zcfg_en got %0d want 0", en_seen); end
    n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL zcfg_busy got %0d want 0", busy_seen); end
    s_valid = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cfg_cols = 10'd3; cfg_rows = 10'd1; start = 1; stall = 0; s_valid = 1; s_data = 24'h11;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({en, zero, row_last, busy, done} !== 5'b0 || din !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got en=%b zero=%b last=%b busy=%b done=%b din=%h want all 0",
               en, zero, row_last, busy, done, din);
    end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_s_ready got %b want 0", s_ready); end
    rst = 0; s_valid = 0;
    @(negedge clk);
    test_single_row("rstmid");
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; s_valid = 0; s_data = '0; cfg_cols = '0; cfg_rows = '0;
    test_reset();
    test_single_row("row1");
    test_two_rows();
    test_gap();
    test_stall();
    test_zero_cfg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_row_feeder.md
PAD_ROW_FEEDER -- requirements
Module: pad_row_feeder

Interface
REQ-001 SHALL provide parameters: Width, default 24, sample width; CntW, default 10, column/row counter width; Pad, default 1, zero beats inserted at each row edge (0..3).
REQ-002 SHALL provide these ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch a frame; sampled in IDLE only.
- cfg_cols  in  CntW  data samples per row.
- cfg_rows  in  CntW  rows per frame.
- s_valid  in  1  upstream sample valid.
- s_data  in  Width  upstream sample.
- s_ready  out  1  upstream sample accepted when high with s_valid.
- stall  in  1  downstream hold request.
- din  out  Width  sample to the 2-stage tap buffer.
- en  out  1  shift-enable to the tap buffer.
- zero  out  1  padding beat; din is 0 when high.
- row_last  out  1  marks the final beat of a row.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.

Function
REQ-003 SHALL implement the FSM states IDLE, LPAD, DATA, RPAD.
REQ-004 In IDLE, start with cfg_cols>=1 and cfg_rows>=1 SHALL latch both cfg values and go to LPAD, or to DATA when Pad==0.
REQ-005 In IDLE, start with cfg_cols==0 or cfg_rows==0 SHALL pulse done on the next cycle, emit no beats and stay in IDLE.
REQ-006 start outside IDLE SHALL be ignored; cfg changes after the start cycle SHALL have no effect on the frame.
REQ-007 A beat is issued in a cycle in which stall==0 and one of these holds:
- state is LPAD or RPAD;
- state is DATA and s_valid && s_ready.
REQ-008 Beat outputs en/zero/din/row_last SHALL be registered: a beat issued in cycle N appears in cycle N+1 with en=1 for exactly one cycle.
REQ-009 A pad beat SHALL present zero=1 and din=0; a data beat SHALL present zero=0 and din equal to the accepted s_data.
REQ-010 In any cycle with no beat issued, en=0 and zero=0 SHALL follow on the next cycle, and din SHALL hold its last value.
REQ-011 s_ready SHALL be combinational and equal (state==DATA) && !stall.
REQ-012 LPAD SHALL issue Pad beats, then go to DATA.
REQ-013 DATA SHALL issue exactly cfg_cols beats; input gaps produce en=0 bubbles only. After the last beat, DATA SHALL go to RPAD, or end the row when Pad==0.
REQ-014 RPAD SHALL issue Pad beats; the final beat of the row SHALL carry row_last=1.
REQ-015 At row end, the row counter SHALL increment and the FSM SHALL go to LPAD/DATA for the next row, or to IDLE after row cfg_rows.
REQ-016 done SHALL assert in the same cycle as the en/row_last of the frame's final beat.
REQ-017 busy SHALL be high from the cycle after an accepted start through the done cycle inclusive.
REQ-018 start in the done cycle SHALL be accepted.
REQ-019 While stall==1, all counters and the state SHALL be frozen, and no sample SHALL be lost or duplicated.
REQ-020 Column and row counters SHALL be CntW bits wide, compare with ==, and never wrap within a legal frame.
REQ-021 Beats per row SHALL equal cfg_cols+2*Pad.

Reset
REQ-022 rst==1 at a clock edge SHALL force the state to IDLE and clear all counters.
REQ-023 On the same edge, din=0 and en, zero, row_last, busy, done SHALL all be 0.
REQ-024 rst SHALL override start, stall and an in-flight frame; s_ready SHALL be 0 from the cycle after reset.

Verification
REQ-025 Pad=1, cols=3, rows=1, s_valid constant, data 0x11,0x22,0x33 -> five consecutive en beats:
- din: 0, 0x11, 0x22, 0x33, 0;
- zero: 1,0,0,0,1;
- row_last and done on the 5th beat.
REQ-026 Pad=1, cols=2, rows=2 -> 8 beats; row_last on beats 4 and 8; done only with beat 8; busy falls on the following cycle.
REQ-027 cols=4, s_valid low for 3 cycles after the 2nd sample -> 3 en=0 bubbles; data order preserved; beat count still 6.
REQ-028 stall held for 2 cycles during DATA -> s_ready=0 and en=0 for those 2 cycles, then resumes with no lost or duplicated sample.
REQ-029 start with cfg_cols=0 -> done one cycle later; en never asserted; busy stays 0.
REQ-030 rst asserted mid-row during DATA -> all outputs 0 on the next cycle; a new start then produces the full REQ-025 sequence.
